// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: shared state encoding and width defaults for the write-port arbiter
package rf_wport_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam logic [AW_DEF-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rf_wport_arbiter_rr_pick2.sv
// rr_pick2: two-input round-robin picker, last=1 means B won the previous tie
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant[0] = valid[0] & (~valid[1] | last);
    grant[1] = valid[1] & (~valid[0] | ~last);
  end
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: round-robin register-file write-port arbiter with lock and registered output
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int ZERO_DROP = 1,
  parameter int LOCK_MAX  = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  input  logic             a_lock,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
  input  logic             b_lock,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic             sel_b,
  output logic [CNT_W-1:0] conflicts
);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  state_t state, state_n;
  logic last_b, sel_q, own_x, timeout, xfer, xlock;
  logic [LCW-1:0] lock_cnt, cnt_n;
  logic [1:0] pick;
  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_data;
  rr_pick2 u_pick (
    .valid({b_valid, a_valid}),
    .last (last_b),
    .grant(pick)
  );
  always_comb begin
    own_x    = state != IDLE;
    timeout  = own_x && lock_cnt == LCW'(LOCK_MAX);
    a_ready  = own_x ? state == OWN_A && a_valid && !timeout : pick[0];
    b_ready  = own_x ? state == OWN_B && b_valid && !timeout : pick[1];
    xfer     = a_ready | b_ready;
    xlock    = b_ready ? b_lock : a_lock;
    sel_b    = b_ready | (sel_q & ~a_ready);
    mux_addr = sel_b ? b_addr : a_addr;
    mux_data = sel_b ? b_data : a_data;
    state_n  = xfer ? (xlock ? (b_ready ? OWN_B : OWN_A) : IDLE) : (timeout ? IDLE : state);
    cnt_n    = own_x && !xfer && !timeout ? lock_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      lock_cnt  <= '0;
      sel_q     <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      conflicts <= '0;
    end else begin
      state    <= state_n;
      lock_cnt <= cnt_n;
      sel_q    <= sel_b;
      rf_we    <= xfer && !(ZERO_DROP != 0 && mux_addr == AW'(REG_ZERO));
      if (xfer) begin
        last_b   <= b_ready;
        rf_waddr <= mux_addr;
        rf_wdata <= mux_data;
      end
      if (a_valid && b_valid && (a_ready ^ b_ready || own_x) && conflicts != '1)
        conflicts <= conflicts + 1'b1;
    end
  end
endmodule
